// File: rtl/instruction_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetcher.
// Hands one instruction at a time to decode; execute-stage redirects squash and refetch.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        misaligned_fault
);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, FAULT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        redir_ok;

    assign redir_ok = (redirect_target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            pc               <= RESET_VECTOR;
            imem_req         <= 1'b0;
            imem_addr        <= RESET_VECTOR;
            if_valid         <= 1'b0;
            if_instruction   <= NOP_INSTR;
            if_pc            <= RESET_VECTOR;
            misaligned_fault <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect beats ack and if_ready; any held instruction is squashed.
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
            if (redir_ok) begin
                pc               <= redirect_target;
                misaligned_fault <= 1'b0;
            end else begin
                misaligned_fault <= 1'b1;
            end
            case (state)
                REQ, DROP: begin
                    if (!imem_ack) begin
                        // Request still in flight: keep req/addr stable and wait it out.
                        state <= DROP;
                    end else if (redir_ok) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_target;
                    end else begin
                        state    <= FAULT;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    if (redir_ok) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_target;
                    end else begin
                        state    <= FAULT;
                        imem_req <= 1'b0;
                    end
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        state          <= HOLD;
                        imem_req       <= 1'b0;
                        if_valid       <= 1'b1;
                        if_instruction <= imem_rdata;
                        if_pc          <= pc;
                        pc             <= pc + 32'd4;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        state          <= REQ;
                        if_valid       <= 1'b0;
                        if_instruction <= NOP_INSTR;
                        imem_req       <= 1'b1;
                        imem_addr      <= pc;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        // Stale data is discarded; a pending misaligned redirect lands in FAULT.
                        if (misaligned_fault) begin
                            state    <= FAULT;
                            imem_req <= 1'b0;
                        end else begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end
                end
                default: begin
                    state    <= FAULT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
